mod_counter: RTL and testbench

MOD_COUNTER -- requirements
Module: mod_counter

---
 rtl/mod_counter_if.sv | 24 ++
 rtl/mod_counter.sv | 71 +++++++
 tb/tb_mod_counter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_counter_if.sv
// Bus bundle for mod_counter: control/load inputs and count/status outputs.
interface mod_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             ent;
  logic             up;
  logic             ld;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             rc;
  logic             wrap;
  logic             done;

  modport master (
    output en, ent, up, ld, d,
    input  q, rc, wrap, done
  );

  modport slave (
    input  en, ent, up, ld, d,
    output q, rc, wrap, done
  );
endinterface

// File: rtl/mod_counter.sv
// Cascadable up/down modulo-MODULUS counter with parallel load, optional one-shot halt,
// combinational ripple carry and a registered rollover pulse.
module mod_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16,
  parameter int unsigned ONESHOT = 0
) (
  input  logic          ck,
  input  logic          clr,
  mod_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] TermHi = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             at_term;
  logic             count_en;

  // Terminal state depends on the live direction, so a change on up is seen at the next edge.
  always_comb begin
    at_term  = bus.up ? (q_q == TermHi) : (q_q == '0);
    count_en = bus.en & bus.ent & ~bus.ld & ~done_q;
  end

  // Next-state: load beats count beats hold; out-of-range loads clamp to the top state.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    done_d = done_q;
    if (bus.ld) begin
      q_d    = (bus.d > TermHi) ? TermHi : bus.d;
      done_d = 1'b0;
    end else if (count_en) begin
      if (at_term) begin
        wrap_d = 1'b1;
        if (ONESHOT != 0) begin
          done_d = 1'b1;
        end else begin
          q_d = bus.up ? '0 : TermHi;
        end
      end else begin
        q_d = bus.up ? (q_q + One) : (q_q - One);
      end
    end
  end

  // State register with asynchronous active-high clear.
  always_ff @(posedge ck or posedge clr) begin
    if (clr) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

  // Ripple carry is gated by ent only, so cascaded stages see it with zero latency.
  always_comb begin
    bus.q    = q_q;
    bus.wrap = wrap_q;
    bus.done = done_q;
    bus.rc   = bus.ent & at_term;
  end

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: directed vector table, hand sequences for one-shot, async clear and
// cascade, then randomized traffic against an arithmetic reference model.
module tb_mod_counter;

  logic ck = 1'b0;
  logic clr_ab = 1'b0;
  logic clr_c = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 ck = ~ck;

  mod_counter_if #(.WIDTH(4)) ifa ();
  mod_counter_if #(.WIDTH(4)) ifb ();
  mod_counter_if #(.WIDTH(4)) ifc0 ();
  mod_counter_if #(.WIDTH(4)) ifc1 ();

  assign ifc1.ent = ifc0.rc;

  mod_counter #(.WIDTH(4), .MODULUS(10), .ONESHOT(0)) u_a (.ck(ck), .clr(clr_ab), .bus(ifa));
  mod_counter #(.WIDTH(4), .MODULUS(10), .ONESHOT(1)) u_b (.ck(ck), .clr(clr_ab), .bus(ifb));
  mod_counter #(.WIDTH(4), .MODULUS(16), .ONESHOT(0)) u_c0 (.ck(ck), .clr(clr_c), .bus(ifc0));
  mod_counter #(.WIDTH(4), .MODULUS(16), .ONESHOT(0)) u_c1 (.ck(ck), .clr(clr_c), .bus(ifc1));

  typedef struct {
    bit       ld;
    bit       en;
    bit       ent;
    bit       up;
    bit [3:0] d;
    int       q;
    bit       wrap;
    bit       rc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic add(input bit ld, input bit en, input bit ent, input bit up, input bit [3:0] d,
                     input int q, input bit wrap, input bit rc);
    vec_t v;
    v.ld = ld; v.en = en; v.ent = ent; v.up = up; v.d = d;
    v.q = q; v.wrap = wrap; v.rc = rc;
    vecs.push_back(v);
  endtask

  // Reference: step the count as plain integer arithmetic; leaving 0..modulus-1 is a rollover.
  function automatic void ref_next(input int modulus, input bit oneshot, input int q,
                                   input bit done, input bit en, input bit ent, input bit up,
                                   input bit ld, input int d, output int nq, output bit nwrap,
                                   output bit ndone);
    int nxt;
    nq = q; nwrap = 1'b0; ndone = done;
    if (ld) begin
      nq = (d < modulus) ? d : modulus - 1;
      ndone = 1'b0;
    end else if (en && ent && !done) begin
      nxt = up ? q + 1 : q - 1;
      if (nxt < 0 || nxt >= modulus) begin
        nwrap = 1'b1;
        if (oneshot) ndone = 1'b1;
        else nq = (nxt + modulus) % modulus;
      end else begin
        nq = nxt;
      end
    end
  endfunction

  function automatic bit ref_rc(input int modulus, input int q, input bit ent, input bit up);
    return ent && (up ? (q == modulus - 1) : (q == 0));
  endfunction

  int       mqa, mqb, nqa, nqb;
  bit       mwa, mwb, mda, mdb, nda, ndb, nwa, nwb;
  bit       r_en, r_ent, r_up, r_ld;
  int       r_d;
  int       cv;

  initial begin
    ifa.en = 0; ifa.ent = 0; ifa.up = 0; ifa.ld = 0; ifa.d = '0;
    ifb.en = 0; ifb.ent = 0; ifb.up = 0; ifb.ld = 0; ifb.d = '0;
    ifc0.en = 0; ifc0.ent = 0; ifc0.up = 0; ifc0.ld = 0; ifc0.d = '0;
    ifc1.en = 0; ifc1.up = 0; ifc1.ld = 0; ifc1.d = '0;

    // Reset state and rc while clear is held.
    #2;
    clr_ab = 1'b1;
    clr_c  = 1'b1;
    ifa.ent = 1'b1; ifa.up = 1'b0;
    #1;
    chk("reset_q", ifa.q, 0);
    chk("reset_wrap", ifa.wrap, 0);
    chk("reset_done", ifb.done, 0);
    chk("reset_rc_down", ifa.rc, 1);
    ifa.up = 1'b1;
    #1;
    chk("reset_rc_up", ifa.rc, 0);
    tick();
    clr_ab = 1'b0;
    clr_c  = 1'b0;

    // Up count through the 9 -> 0 rollover.
    for (int i = 1; i <= 12; i++) begin
      add(0, 1, 1, 1, 4'h0, i % 10, (i == 10), (i == 9));
    end
    // Clamped load, then down count through 0 -> 9.
    add(1, 0, 1, 0, 4'hE, 9, 0, 0);
    for (int i = 8; i >= -2; i--) begin
      add(0, 1, 1, 0, 4'h0, (i + 10) % 10, (i == -1), (i == 0));
    end
    // Load beats count at terminal state; ent=0 blocks count and rc.
    add(0, 1, 1, 1, 4'h0, 9, 0, 1);
    add(1, 1, 1, 1, 4'h2, 2, 0, 0);
    add(0, 1, 0, 1, 4'h0, 2, 0, 0);

    foreach (vecs[i]) begin
      ifa.ld = vecs[i].ld; ifa.en = vecs[i].en; ifa.ent = vecs[i].ent;
      ifa.up = vecs[i].up; ifa.d = vecs[i].d;
      tick();
      chk($sformatf("vec%0d_q", i), ifa.q, vecs[i].q);
      chk($sformatf("vec%0d_wrap", i), ifa.wrap, vecs[i].wrap);
      chk($sformatf("vec%0d_rc", i), ifa.rc, vecs[i].rc);
    end

    // Asynchronous clear mid-cycle at q=5 with load and count requested.
    ifa.ld = 1; ifa.d = 4'h5; ifa.en = 0;
    tick();
    chk("async_pre_q", ifa.q, 5);
    #2;
    clr_ab = 1'b1;
    ifa.ld = 1; ifa.d = 4'h7; ifa.en = 1; ifa.ent = 1; ifa.up = 0;
    #1;
    chk("async_q_now", ifa.q, 0);
    chk("async_rc", ifa.rc, 1);
    tick();
    chk("async_hold_q", ifa.q, 0);
    ifa.ld = 0; ifa.up = 1;
    clr_ab = 1'b0;
    tick();
    chk("async_first_count", ifa.q, 1);
    ifa.en = 0;

    // One-shot halt at terminal count, released by load.
    ifb.ld = 1; ifb.d = 4'h7;
    tick();
    chk("os_load_q", ifb.q, 7);
    ifb.ld = 0; ifb.en = 1; ifb.ent = 1; ifb.up = 1;
    tick();
    chk("os_q8", ifb.q, 8);
    tick();
    chk("os_q9", ifb.q, 9);
    chk("os_q9_done", ifb.done, 0);
    tick();
    chk("os_halt_q", ifb.q, 9);
    chk("os_halt_done", ifb.done, 1);
    chk("os_halt_wrap", ifb.wrap, 1);
    tick();
    chk("os_hold_q", ifb.q, 9);
    chk("os_hold_wrap", ifb.wrap, 0);
    chk("os_hold_rc", ifb.rc, 1);
    ifb.ld = 1; ifb.d = 4'h3;
    tick();
    chk("os_reload_q", ifb.q, 3);
    chk("os_reload_done", ifb.done, 0);
    ifb.ld = 0; ifb.en = 0;

    // Cascade: 8'hFF -> 8'h00 on one edge.
    ifc0.ld = 1; ifc1.ld = 1; ifc0.d = 4'hF; ifc1.d = 4'hF;
    ifc0.ent = 1; ifc0.up = 1; ifc1.up = 1;
    tick();
    chk("casc_load", {ifc1.q, ifc0.q}, 8'hFF);
    chk("casc_rc0", ifc0.rc, 1);
    ifc0.ld = 0; ifc1.ld = 0; ifc0.en = 1; ifc1.en = 1;
    tick();
    chk("casc_roll", {ifc1.q, ifc0.q}, 8'h00);
    chk("casc_wrap_hi", ifc1.wrap, 1);
    cv = 0;
    for (int i = 0; i < 600; i++) begin
      r_en = ($urandom_range(0, 3) != 0);
      r_up = ($urandom_range(0, 4) != 0);
      ifc0.en = r_en; ifc1.en = r_en; ifc0.up = r_up; ifc1.up = r_up;
      tick();
      if (r_en) cv = (r_up ? cv + 1 : cv + 255) % 256;
      chk("casc_rand", {ifc1.q, ifc0.q}, cv);
    end

    // Randomized traffic on both single-stage counters, with occasional async clears.
    clr_ab = 1'b1;
    #1;
    clr_ab = 1'b0;
    mqa = 0; mqb = 0; mwa = 0; mwb = 0; mda = 0; mdb = 0;
    for (int i = 0; i < 1500; i++) begin
      r_en  = ($urandom_range(0, 3) != 0);
      r_ent = ($urandom_range(0, 5) != 0);
      r_up  = ($urandom_range(0, 2) != 0);
      r_ld  = ($urandom_range(0, 15) == 0);
      r_d   = $urandom_range(0, 15);
      ifa.en = r_en; ifa.ent = r_ent; ifa.up = r_up; ifa.ld = r_ld; ifa.d = r_d[3:0];
      ifb.en = r_en; ifb.ent = r_ent; ifb.up = r_up; ifb.ld = r_ld; ifb.d = r_d[3:0];
      #1;
      chk("rand_rc_a", ifa.rc, ref_rc(10, mqa, r_ent, r_up));
      chk("rand_rc_b", ifb.rc, ref_rc(10, mqb, r_ent, r_up));
      if ($urandom_range(0, 59) == 0) begin
        clr_ab = 1'b1;
        #1;
        chk("rand_clr_q", ifa.q, 0);
        chk("rand_clr_done", ifb.done, 0);
        mqa = 0; mqb = 0; mwa = 0; mwb = 0; mda = 0; mdb = 0;
        tick();
        clr_ab = 1'b0;
        continue;
      end
      ref_next(10, 1'b0, mqa, mda, r_en, r_ent, r_up, r_ld, r_d, nqa, nwa, nda);
      ref_next(10, 1'b1, mqb, mdb, r_en, r_ent, r_up, r_ld, r_d, nqb, nwb, ndb);
      tick();
      mqa = nqa; mwa = nwa; mda = nda;
      mqb = nqb; mwb = nwb; mdb = ndb;
      chk("rand_q_a", ifa.q, mqa);
      chk("rand_wrap_a", ifa.wrap, mwa);
      chk("rand_done_a", ifa.done, mda);
      chk("rand_q_b", ifb.q, mqb);
      chk("rand_wrap_b", ifb.wrap, mwb);
      chk("rand_done_b", ifb.done, mdb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
